usb_rx: RTL and testbench
=========================

# usb_rx

Byte-level packet receiver for the collect-side USB command link, and the counterpart of the command transmitter. Parses the received byte stream `SYNC, PID, [LEN0, LEN1, CMD bytes, CRC]` into a packet type code and a 32-bit command word. Uses the same `fs`/`fd` start/done handshake as the transmitter, so the collect controller can arm it and collect one packet per handshake.

## Interface
- `TIMEOUT`, default 1023: maximum clk cycles allowed between consecutive bytes inside a packet; width 10 bits.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `fs  in  1`: arm. A high level starts or holds reception.
- `com_rxd  in  8`: received byte, valid only when `com_rxv` is high.
- `com_rxv  in  1`: byte strobe, one cycle per byte.
- `fd  out  1`: packet done (result valid). Held until `fs` falls.
- `err  out  1`: packet rejected. Valid while `fd` is high.
- `btype  out  4`: packet type: INIT 0, ACK 1, NAK 2, STL 3, DIDX 5, DPARAM 6, DDIDX 7.
- `data_cmd  out  32`: decoded command word; unused bits are 0.

## Operation
- **States:**
  - IDLE → WAIT unconditionally.
  - WAIT → HUNT when `fs` is high.
  - HUNT: bytes other than 0x01 are discarded. 0x01 → PID.
  - PID:
    - 0x2D → ACK.
    - 0xA5 → NAK.
    - 0xE1 → STL.
    - Each of these three goes straight to DONE.
    - 0x1E → LEN0.
    - Any other byte → ERR.
  - LEN0: byte must be 0x00, else ERR. Then → LEN1.
  - LEN1: `dlen` = byte, which must be 1 or 2, else ERR. Then → CMD.
  - CMD: a byte counter `num` advances on each byte. After byte `dlen-1` → CRC.
  - CRC → DONE.
  - DONE: `fd`=1. When `fs` is low → WAIT.
  - ERR: `fd`=1, `err`=1. When `fs` is low → WAIT.
- **Header** is the first CMD byte, upper nibble:
  - 0x9 with `dlen`=1 → DIDX, `data_cmd[31:28]` = low nibble.
  - 0x1 with `dlen`=1 → DDIDX, `data_cmd[27:24]` = low nibble.
  - 0x5 with `dlen`=2 → DPARAM:
    - `[23:20]` = first low nibble.
    - Second byte: `[19:16]` = upper nibble (filt_up), `[15:12]` = lower nibble (filt_low).
  - Any other head or length combination → ERR after the CRC byte.
- **Staging:** `btype` and `data_cmd` are built in shadow registers. They are copied to the outputs only on entry to DONE. ERR leaves the previous output values unchanged.
- **Byte-gap timeout:** a counter runs in PID through CRC and clears on each `com_rxv`. When it reaches `TIMEOUT` → ERR.
- **Disarm:** `fs` falling in any state from HUNT through CRC → WAIT, with no `fd` pulse.
- **Reset:** asserting `rst` at any time, including mid-packet, returns to IDLE. All outputs and shadow registers are set to 0.

## Timing
- Reset values: `fd`=0, `err`=0, `btype`=0, `data_cmd`=0.
- Every output is a register.
- `fd` rises one cycle after the last byte is sampled: the PID byte for handshake packets, the CRC byte for command packets. `btype` and `data_cmd` are valid in the same cycle.
- One byte per cycle is supported. Back-to-back `com_rxv` strobes are all accepted.
- `com_rxv` pulses in IDLE, WAIT, DONE or ERR are ignored.
- The timeout fires exactly `TIMEOUT` cycles after the last accepted byte.
- Simultaneous events:
  - A byte arriving in the timeout cycle: the byte wins and the counter clears.
  - `fs` falling in the same cycle as the final byte: disarm wins and `fd` stays low.

## Configuration
- `USB_RX_CRC_CHECK_EN` defined:
  - CMD bytes feed a `crc5` instance (enable = CMD-state strobe).
  - The received CRC byte is compared with the 8-bit CRC output.
  - A mismatch → ERR instead of DONE.
- Undefined: the CRC byte is consumed and ignored, and no `crc5` is instantiated.

## Structure
- Shared package `usb_pkg` holds:
  - BAG_* type codes.
  - PID_* values (SYNC 0x01, ACK 0x2D, NAK 0xA5, STALL 0xE1, CMD 0x1E).
  - HEAD_* nibbles (DDIDX 0x1, DPARAM 0x5, DIDX 0x9).
- The transmitter imports the same package.
- Sub-module: the existing `crc5` (clk, enable, din, dout), instantiated only under the macro.
- Everything else is a single FSM with its counters.

## Test plan
- `fs`=1, bytes 0x01, 0x2D → `fd`=1 one cycle later, `btype`=1, `err`=0, `data_cmd`=0. Drop `fs` → `fd`=0 on the next cycle.
- Bytes 0x01, 0x1E, 0x00, 0x02, 0x53, 0xA4, CRC → `btype`=6, `data_cmd`=0x003A4000.
- Bytes 0x01, 0x1E, 0x00, 0x01, 0x97, CRC → `btype`=5, `data_cmd`=0x70000000. Repeat with 0x12 → `btype`=7, `data_cmd`=0x02000000.
- Garbage 0x55, 0xFF, then 0x01, 0xA5 → garbage discarded, `btype`=2. PID 0x77 → `err`=1 and `btype` keeps its prior value.
- With the macro defined, a corrupted CRC byte → `err`=1. Without the macro, the same stream → `err`=0.
- Stop the stream after LEN1 for `TIMEOUT` cycles → `err`=1. Assert `rst` mid-packet → all outputs 0 and the FSM in IDLE.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB command link (receiver and transmitter):
// packet type codes, PID values, command head nibbles and the CRC5 byte step.
package usb_pkg;

    // Packet type codes reported on btype
    localparam logic [3:0] BAG_INIT   = 4'd0;
    localparam logic [3:0] BAG_ACK    = 4'd1;
    localparam logic [3:0] BAG_NAK    = 4'd2;
    localparam logic [3:0] BAG_STL    = 4'd3;
    localparam logic [3:0] BAG_DIDX   = 4'd5;
    localparam logic [3:0] BAG_DPARAM = 4'd6;
    localparam logic [3:0] BAG_DDIDX  = 4'd7;

    // Byte values on the wire
    localparam logic [7:0] PID_SYNC  = 8'h01;
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    localparam logic [7:0] PID_STALL = 8'hE1;
    localparam logic [7:0] PID_CMD   = 8'h1E;

    // Upper nibble of the first command byte
    localparam logic [3:0] HEAD_DDIDX  = 4'h1;
    localparam logic [3:0] HEAD_DPARAM = 4'h5;
    localparam logic [3:0] HEAD_DIDX   = 4'h9;

    // USB CRC5 (x^5+x^2+1) over one byte, LSB first, seed 5'h1F, inverted result
    function automatic logic [7:0] crc5_byte(input logic [7:0] din);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ din[i])
                c = (c >> 1) ^ 5'h14;
            else
                c = c >> 1;
        end
        return {3'b000, ~c};
    endfunction

endpackage

// File: rtl/crc5.sv
// CRC5 check value of the most recent enabled byte, zero-extended to 8 bits.
// The register holds its value while enable is low.
module crc5
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       enable,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Capture the CRC of each strobed byte
    always_ff @(posedge clk) begin
        if (enable)
            dout <= crc5_byte(din);
    end

endmodule

// File: rtl/usb_rx.sv
// Byte-level USB command packet receiver: SYNC, PID, [LEN0, LEN1, CMD.., CRC].
// Handshake: fs arms, fd reports a result and is held until fs falls.
// Optional CRC check of the command bytes: define USB_RX_CRC_CHECK_EN.
// dbg_state exposes the FSM state (S_* encoding below) for observation.
module usb_rx
    import usb_pkg::*;
#(
    parameter logic [9:0] TIMEOUT = 10'd1023
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    input  logic [7:0]  com_rxd,
    input  logic        com_rxv,
    output logic        fd,
    output logic        err,
    output logic [3:0]  btype,
    output logic [31:0] data_cmd,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_WAIT = 4'd1;
    localparam logic [3:0] S_HUNT = 4'd2;
    localparam logic [3:0] S_PID  = 4'd3;
    localparam logic [3:0] S_LEN0 = 4'd4;
    localparam logic [3:0] S_LEN1 = 4'd5;
    localparam logic [3:0] S_CMD  = 4'd6;
    localparam logic [3:0] S_CRC  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;
    localparam logic [3:0] S_ERR  = 4'd9;

    logic [3:0]  state, state_nx;
    logic [9:0]  gap;        // idle cycles since the last accepted byte
    logic [1:0]  dlen;       // command byte count (1 or 2)
    logic [1:0]  num;        // index of the next command byte
    logic [3:0]  sh_btype;   // staged packet type
    logic [31:0] sh_cmd;     // staged command word
    logic        sh_ok;      // head/length combination is legal
    logic [3:0]  pid_type;
    logic        in_packet;
    logic        timeout;
    logic        cmd_stb;
    logic        crc_good;

    assign dbg_state = state;
    assign in_packet = (state == S_PID) || (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_CMD) || (state == S_CRC);
    assign timeout   = in_packet && !com_rxv && (gap == TIMEOUT - 10'd1);
    assign cmd_stb   = (state == S_CMD) && com_rxv;

`ifdef USB_RX_CRC_CHECK_EN
    logic [7:0] crc_dout;

    crc5 u_crc5 (
        .clk    (clk),
        .enable (cmd_stb),
        .din    (com_rxd),
        .dout   (crc_dout)
    );

    assign crc_good = sh_ok && (com_rxd == crc_dout);
`else
    assign crc_good = sh_ok;
`endif

    // Map a handshake PID byte to its packet type
    always_comb begin
        pid_type = BAG_INIT;
        case (com_rxd)
            PID_ACK:   pid_type = BAG_ACK;
            PID_NAK:   pid_type = BAG_NAK;
            PID_STALL: pid_type = BAG_STL;
            default:   pid_type = BAG_INIT;
        endcase
    end

    // Next-state logic: disarm beats a byte, a byte beats the timeout
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = S_WAIT;
            S_WAIT: if (fs) state_nx = S_HUNT;
            S_HUNT, S_PID, S_LEN0, S_LEN1, S_CMD, S_CRC: begin
                if (!fs) begin
                    state_nx = S_WAIT;
                end else if (com_rxv) begin
                    case (state)
                        S_HUNT: if (com_rxd == PID_SYNC) state_nx = S_PID;
                        S_PID: begin
                            if (com_rxd == PID_ACK || com_rxd == PID_NAK || com_rxd == PID_STALL)
                                state_nx = S_DONE;
                            else if (com_rxd == PID_CMD)
                                state_nx = S_LEN0;
                            else
                                state_nx = S_ERR;
                        end
                        S_LEN0: state_nx = (com_rxd == 8'h00) ? S_LEN1 : S_ERR;
                        S_LEN1: state_nx = (com_rxd == 8'h01 || com_rxd == 8'h02) ? S_CMD : S_ERR;
                        S_CMD:  if (num == dlen - 2'd1) state_nx = S_CRC;
                        default: state_nx = crc_good ? S_DONE : S_ERR;
                    endcase
                end else if (timeout) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE, S_ERR: if (!fs) state_nx = S_WAIT;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register, byte-gap counter and length/index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gap   <= '0;
            dlen  <= '0;
            num   <= '0;
        end else begin
            state <= state_nx;
            if (com_rxv || !in_packet)
                gap <= '0;
            else
                gap <= gap + 10'd1;
            if (state == S_HUNT)
                num <= '0;
            if (state == S_LEN1 && com_rxv)
                dlen <= com_rxd[1:0];
            if (cmd_stb)
                num <= num + 2'd1;
        end
    end

    // Shadow decode of command bytes and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd       <= 1'b0;
            err      <= 1'b0;
            btype    <= '0;
            data_cmd <= '0;
            sh_btype <= '0;
            sh_cmd   <= '0;
            sh_ok    <= 1'b0;
        end else begin
            fd  <= (state_nx == S_DONE) || (state_nx == S_ERR);
            err <= (state_nx == S_ERR);
            if (state == S_HUNT) begin
                sh_btype <= BAG_INIT;
                sh_cmd   <= '0;
                sh_ok    <= 1'b0;
            end
            if (cmd_stb) begin
                if (num == 2'd0) begin
                    sh_ok <= 1'b0;
                    if (com_rxd[7:4] == HEAD_DIDX && dlen == 2'd1) begin
                        sh_btype       <= BAG_DIDX;
                        sh_cmd[31:28]  <= com_rxd[3:0];
                        sh_ok          <= 1'b1;
                    end else if (com_rxd[7:4] == HEAD_DDIDX && dlen == 2'd1) begin
                        sh_btype       <= BAG_DDIDX;
                        sh_cmd[27:24]  <= com_rxd[3:0];
                        sh_ok          <= 1'b1;
                    end else if (com_rxd[7:4] == HEAD_DPARAM && dlen == 2'd2) begin
                        sh_btype       <= BAG_DPARAM;
                        sh_cmd[23:20]  <= com_rxd[3:0];
                        sh_ok          <= 1'b1;
                    end
                end else begin
                    // filt_up in [19:16], filt_low in [15:12]
                    sh_cmd[19:12] <= com_rxd;
                end
            end
            if (state_nx == S_DONE && state == S_PID) begin
                btype    <= pid_type;
                data_cmd <= '0;
            end else if (state_nx == S_DONE && state == S_CRC) begin
                btype    <= sh_btype;
                data_cmd <= sh_cmd;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx; each task drives one scenario and checks inline.
module tb_usb_rx;

    localparam int TMO = 1023;

    logic        clk;
    logic        rst;
    logic        fs;
    logic [7:0]  com_rxd;
    logic        com_rxv;
    logic        fd;
    logic        err;
    logic [3:0]  btype;
    logic [31:0] data_cmd;
    logic [3:0]  dbg_state;

    int n_pass = 0;
    int n_total = 0;

    usb_rx dut (
        .clk       (clk),
        .rst       (rst),
        .fs        (fs),
        .com_rxd   (com_rxd),
        .com_rxv   (com_rxv),
        .fd        (fd),
        .err       (err),
        .btype     (btype),
        .data_cmd  (data_cmd),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC5 of a single byte (x^5+x^2+1, LSB first, seed 1F, inverted)
    function automatic logic [7:0] crc_of(input logic [7:0] b);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return {3'b000, ~c};
    endfunction

    // Driver tasks: all input changes happen on the falling edge
    task automatic put(input logic [7:0] b);
        com_rxd = b;
        com_rxv = 1'b1;
        @(negedge clk);
        com_rxv = 1'b0;
        com_rxd = 8'h00;
    endtask

    task automatic arm();
        fs = 1'b1;
        @(negedge clk);
    endtask

    task automatic disarm();
        fs = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        n_total++; if (fd !== 1'b0) $display("FAIL reset_fd got %0b exp 0", fd); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else n_pass++;
        n_total++; if (btype !== 4'd0) $display("FAIL reset_btype got %0d exp 0", btype); else n_pass++;
        n_total++; if (data_cmd !== 32'h0) $display("FAIL reset_cmd got %h exp 0", data_cmd); else n_pass++;
        n_total++; if (dbg_state !== 4'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    endtask

    task automatic test_ack();
        arm();
        put(8'h01);
        n_total++; if (fd !== 1'b0) $display("FAIL ack_early_fd got %0b exp 0", fd); else n_pass++;
        put(8'h2D);
        n_total++; if (fd !== 1'b1) $display("FAIL ack_fd got %0b exp 1", fd); else n_pass++;
        n_total++; if (btype !== 4'd1) $display("FAIL ack_btype got %0d exp 1", btype); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL ack_err got %0b exp 0", err); else n_pass++;
        n_total++; if (data_cmd !== 32'h0) $display("FAIL ack_cmd got %h exp 0", data_cmd); else n_pass++;
        idle(2);
        n_total++; if (fd !== 1'b1) $display("FAIL ack_fd_held got %0b exp 1", fd); else n_pass++;
        disarm();
        n_total++; if (fd !== 1'b0) $display("FAIL ack_fd_drop got %0b exp 0", fd); else n_pass++;
    endtask

    task automatic test_cmd(input string name, input logic [7:0] len,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [3:0] exp_type, input logic [31:0] exp_cmd);
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(len);
        put(b0);
        if (len == 8'd2) put(b1);
        n_total++; if (fd !== 1'b0) $display("FAIL %s_pre_crc_fd got %0b exp 0", name, fd); else n_pass++;
        put(len == 8'd2 ? crc_of(b1) : crc_of(b0));
        n_total++; if (fd !== 1'b1) $display("FAIL %s_fd got %0b exp 1", name, fd); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL %s_err got %0b exp 0", name, err); else n_pass++;
        n_total++; if (btype !== exp_type) $display("FAIL %s_btype got %0d exp %0d", name, btype, exp_type); else n_pass++;
        n_total++; if (data_cmd !== exp_cmd) $display("FAIL %s_cmd got %h exp %h", name, data_cmd, exp_cmd); else n_pass++;
        disarm();
    endtask

    task automatic test_hunt_and_bad_pid();
        arm();
        put(8'h55); put(8'hFF);
        n_total++; if (fd !== 1'b0) $display("FAIL hunt_garbage_fd got %0b exp 0", fd); else n_pass++;
        put(8'h01); put(8'hA5);
        n_total++; if (btype !== 4'd2) $display("FAIL nak_btype got %0d exp 2", btype); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL nak_err got %0b exp 0", err); else n_pass++;
        disarm();
        arm();
        put(8'h01); put(8'h77);
        n_total++; if (fd !== 1'b1) $display("FAIL badpid_fd got %0b exp 1", fd); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL badpid_err got %0b exp 1", err); else n_pass++;
        n_total++; if (btype !== 4'd2) $display("FAIL badpid_btype got %0d exp 2", btype); else n_pass++;
        disarm();
        n_total++; if (err !== 1'b0) $display("FAIL badpid_err_clear got %0b exp 0", err); else n_pass++;
    endtask

    task automatic test_bad_frames();
        // DPARAM head with a one-byte length is rejected after the CRC byte
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(8'h01); put(8'h53);
        n_total++; if (fd !== 1'b0) $display("FAIL badhead_early got %0b exp 0", fd); else n_pass++;
        put(crc_of(8'h53));
        n_total++; if (err !== 1'b1) $display("FAIL badhead_err got %0b exp 1", err); else n_pass++;
        n_total++; if (btype !== 4'd2) $display("FAIL badhead_btype got %0d exp 2", btype); else n_pass++;
        disarm();
        // Length 3 is rejected at LEN1
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(8'h03);
        n_total++; if (err !== 1'b1) $display("FAIL badlen_err got %0b exp 1", err); else n_pass++;
        disarm();
        // Non-zero LEN0 is rejected
        arm();
        put(8'h01); put(8'h1E); put(8'h01);
        n_total++; if (err !== 1'b1) $display("FAIL badlen0_err got %0b exp 1", err); else n_pass++;
        disarm();
    endtask

    task automatic test_crc();
        logic exp_err;
`ifdef USB_RX_CRC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(8'h01); put(8'h97);
        put(crc_of(8'h97) ^ 8'hFF);
        n_total++; if (fd !== 1'b1) $display("FAIL crc_fd got %0b exp 1", fd); else n_pass++;
        n_total++; if (err !== exp_err) $display("FAIL crc_err got %0b exp %0b", err, exp_err); else n_pass++;
        disarm();
    endtask

    task automatic test_disarm_final();
        arm();
        put(8'h01);
        fs = 1'b0;
        put(8'hE1);
        n_total++; if (fd !== 1'b0) $display("FAIL disarm_fd got %0b exp 0", fd); else n_pass++;
        n_total++; if (dbg_state !== 4'd1) $display("FAIL disarm_state got %0d exp 1", dbg_state); else n_pass++;
        n_total++; if (btype === 4'd3) $display("FAIL disarm_btype got %0d exp not 3", btype); else n_pass++;
    endtask

    task automatic test_back_to_back();
        arm();
        put(8'h01); put(8'hE1);
        n_total++; if (btype !== 4'd3) $display("FAIL b2b_stl got %0d exp 3", btype); else n_pass++;
        disarm();
        arm();
        put(8'h01); put(8'h2D);
        n_total++; if (btype !== 4'd1) $display("FAIL b2b_ack got %0d exp 1", btype); else n_pass++;
        disarm();
    endtask

    task automatic test_timeout();
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(8'h01);
        idle(TMO - 1);
        n_total++; if (err !== 1'b0) $display("FAIL tmo_early_err got %0b exp 0", err); else n_pass++;
        idle(1);
        n_total++; if (err !== 1'b1) $display("FAIL tmo_err got %0b exp 1", err); else n_pass++;
        n_total++; if (fd !== 1'b1) $display("FAIL tmo_fd got %0b exp 1", fd); else n_pass++;
        disarm();
        // A byte arriving in the timeout cycle is accepted
        arm();
        put(8'h01); put(8'h1E); put(8'h00); put(8'h01);
        idle(TMO - 1);
        put(8'h97);
        n_total++; if (fd !== 1'b0) $display("FAIL tmo_race_fd got %0b exp 0", fd); else n_pass++;
        put(crc_of(8'h97));
        n_total++; if (err !== 1'b0) $display("FAIL tmo_race_err got %0b exp 0", err); else n_pass++;
        n_total++; if (btype !== 4'd5) $display("FAIL tmo_race_btype got %0d exp 5", btype); else n_pass++;
        disarm();
    endtask

    task automatic test_rst_mid();
        arm();
        put(8'h01); put(8'h2D);
        disarm();
        arm();
        put(8'h01); put(8'h1E);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (dbg_state !== 4'd0) $display("FAIL rstmid_state got %0d exp 0", dbg_state); else n_pass++;
        n_total++; if (btype !== 4'd0) $display("FAIL rstmid_btype got %0d exp 0", btype); else n_pass++;
        n_total++; if (fd !== 1'b0) $display("FAIL rstmid_fd got %0b exp 0", fd); else n_pass++;
        n_total++; if (data_cmd !== 32'h0) $display("FAIL rstmid_cmd got %h exp 0", data_cmd); else n_pass++;
        fs  = 1'b0;
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        rst     = 1'b1;
        fs      = 1'b0;
        com_rxd = 8'h00;
        com_rxv = 1'b0;
        idle(3);
        test_reset();
        rst = 1'b0;
        idle(2);
        test_ack();
        test_cmd("dparam", 8'd2, 8'h53, 8'hA4, 4'd6, 32'h003A4000);
        test_cmd("didx",   8'd1, 8'h97, 8'h00, 4'd5, 32'h70000000);
        test_cmd("ddidx",  8'd1, 8'h12, 8'h00, 4'd7, 32'h02000000);
        test_hunt_and_bad_pid();
        test_bad_frames();
        test_crc();
        test_disarm_final();
        test_back_to_back();
        test_timeout();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
